// File: rtl/dtp_pkg.sv
// Shared types for the per-port DTP timestamp block: message encodings, FSM states, tx payload.
package dtp_pkg;

    localparam int unsigned TS_W  = 53;
    localparam int unsigned MSG_W = 2;

    typedef enum logic [MSG_W-1:0] {
        MSG_INIT     = 2'b00,
        MSG_INIT_ACK = 2'b01,
        MSG_BEACON   = 2'b10,
        MSG_RSVD     = 2'b11
    } msg_type_e;

    typedef enum logic [1:0] {
        ST_DOWN      = 2'd0,
        ST_INIT_SEND = 2'd1,
        ST_INIT_WAIT = 2'd2,
        ST_SYNCED    = 2'd3
    } state_e;

    typedef struct packed {
        msg_type_e       msg_type;
        logic [TS_W-1:0] ts;
    } tx_msg_t;

endpackage

// File: rtl/dtp_tx_arb.sv
// Tx message arbiter: pending INIT_ACK/INIT/BEACON flags, fixed-priority load and a
// valid/ready output register whose payload holds until accepted.
module dtp_tx_arb
    import dtp_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            ack_req_i,
    input  logic [TS_W-1:0] ack_ts_i,
    input  logic            init_req_i,
    input  logic            beacon_req_i,
    input  logic [TS_W-1:0] local_ts_i,
    input  logic            tx_ready_i,
    output logic            tx_valid_o,
    output tx_msg_t         tx_msg_o
);

    logic            ack_pend_q, ack_pend_d;
    logic [TS_W-1:0] ack_ts_q, ack_ts_d;
    logic            init_pend_q, init_pend_d;
    logic            beacon_pend_q, beacon_pend_d;
    logic            valid_q, valid_d;
    tx_msg_t         msg_q, msg_d;

    // A new request arriving in the cycle its flag is consumed stays pending for a later load.
    always_comb begin
        ack_pend_d    = ack_pend_q;
        ack_ts_d      = ack_ts_q;
        init_pend_d   = init_pend_q;
        beacon_pend_d = beacon_pend_q;
        valid_d       = valid_q;
        msg_d         = msg_q;

        if (valid_q && tx_ready_i) begin
            valid_d = 1'b0;
        end

        if (!valid_q) begin
            if (ack_pend_q) begin
                valid_d        = 1'b1;
                msg_d.msg_type = MSG_INIT_ACK;
                msg_d.ts       = ack_ts_q;
                ack_pend_d     = 1'b0;
            end else if (init_pend_q) begin
                valid_d        = 1'b1;
                msg_d.msg_type = MSG_INIT;
                msg_d.ts       = local_ts_i;
                init_pend_d    = 1'b0;
            end else if (beacon_pend_q) begin
                valid_d        = 1'b1;
                msg_d.msg_type = MSG_BEACON;
                msg_d.ts       = local_ts_i;
                beacon_pend_d  = 1'b0;
            end
        end

        if (ack_req_i) begin
            ack_pend_d = 1'b1;
            ack_ts_d   = ack_ts_i;
        end
        if (init_req_i) begin
            init_pend_d = 1'b1;
        end
        if (beacon_req_i) begin
            beacon_pend_d = 1'b1;
        end

        if (flush_i) begin
            ack_pend_d    = 1'b0;
            init_pend_d   = 1'b0;
            beacon_pend_d = 1'b0;
            valid_d       = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_pend_q    <= 1'b0;
            ack_ts_q      <= '0;
            init_pend_q   <= 1'b0;
            beacon_pend_q <= 1'b0;
            valid_q       <= 1'b0;
            msg_q         <= '0;
        end else begin
            ack_pend_q    <= ack_pend_d;
            ack_ts_q      <= ack_ts_d;
            init_pend_q   <= init_pend_d;
            beacon_pend_q <= beacon_pend_d;
            valid_q       <= valid_d;
            msg_q         <= msg_d;
        end
    end

    assign tx_valid_o = valid_q;
    assign tx_msg_o   = msg_q;

endmodule

// File: rtl/dtp_port_timestamp.sv
// Per-port DTP local timestamp: free-running counter, INIT/INIT_ACK delay measurement,
// periodic beacons and max(local, peer+delay) alignment on received beacons.
module dtp_port_timestamp
    import dtp_pkg::*;
#(
    parameter int unsigned INCR          = 1,
    parameter int unsigned DELAY_W       = 16,
    parameter int unsigned BEACON_PERIOD = 200,
    parameter int unsigned INIT_TIMEOUT  = 4096
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               link_up,
    input  logic               rx_msg_valid,
    input  logic [1:0]         rx_msg_type,
    input  logic [TS_W-1:0]    rx_msg_ts,
    output logic               tx_msg_valid,
    input  logic               tx_msg_ready,
    output logic [1:0]         tx_msg_type,
    output logic [TS_W-1:0]    tx_msg_ts,
    output logic [TS_W-1:0]    local_ts,
    output logic [DELAY_W-1:0] delay,
    output logic               synced
);

    localparam int unsigned TMR_MAX = (INIT_TIMEOUT > BEACON_PERIOD) ? INIT_TIMEOUT : BEACON_PERIOD;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);

    state_e             state_q, state_d;
    logic [TS_W-1:0]    local_ts_q, local_ts_d;
    logic [TS_W-1:0]    t_sent_q, t_sent_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               synced_q, synced_d;

    logic               rx_init, rx_ack, rx_beacon;
    logic               tx_hs;
    logic               init_req, beacon_req, ack_req;
    tx_msg_t            tx_msg;
    logic [TS_W-1:0]    cand, base;
    logic [TS_W-1:0]    rtt_half;
    logic [DELAY_W-1:0] delay_meas;

    assign rx_init   = rx_msg_valid && (msg_type_e'(rx_msg_type) == MSG_INIT);
    assign rx_ack    = rx_msg_valid && (msg_type_e'(rx_msg_type) == MSG_INIT_ACK);
    assign rx_beacon = rx_msg_valid && (msg_type_e'(rx_msg_type) == MSG_BEACON);
    assign tx_hs     = tx_msg_valid && tx_msg_ready;
    assign ack_req   = rx_init && (state_q != ST_DOWN);

    // Half the round trip, saturated to the delay width.
    assign rtt_half   = (local_ts_q - t_sent_q) >> 1;
    assign delay_meas = (|rtt_half[TS_W-1:DELAY_W]) ? '1 : rtt_half[DELAY_W-1:0];

    always_comb begin
        cand = rx_msg_ts + TS_W'(delay_q);
        base = local_ts_q;
        if ((state_q == ST_SYNCED) && rx_beacon && (cand > local_ts_q)) begin
            base = cand;
        end
        local_ts_d = base + TS_W'(INCR);
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        t_sent_d   = t_sent_q;
        delay_d    = delay_q;
        init_req   = 1'b0;
        beacon_req = 1'b0;

        case (state_q)
            ST_DOWN: begin
                if (link_up) begin
                    state_d  = ST_INIT_SEND;
                    init_req = 1'b1;
                end
            end
            ST_INIT_SEND: begin
                // The held payload equals local_ts at load, so it doubles as t_sent.
                if (tx_hs && (tx_msg.msg_type == MSG_INIT)) begin
                    state_d  = ST_INIT_WAIT;
                    timer_d  = '0;
                    t_sent_d = tx_msg.ts;
                end
            end
            ST_INIT_WAIT: begin
                if (rx_ack && (rx_msg_ts == t_sent_q)) begin
                    delay_d = delay_meas;
                    state_d = ST_SYNCED;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(INIT_TIMEOUT - 1)) begin
                    state_d  = ST_INIT_SEND;
                    init_req = 1'b1;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_SYNCED: begin
                if (timer_q == TMR_W'(BEACON_PERIOD - 1)) begin
                    timer_d    = '0;
                    beacon_req = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_DOWN;
            end
        endcase

        if (!link_up) begin
            state_d    = ST_DOWN;
            timer_d    = '0;
            init_req   = 1'b0;
            beacon_req = 1'b0;
        end

        synced_d = (state_d == ST_SYNCED);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_DOWN;
            local_ts_q <= '0;
            t_sent_q   <= '0;
            delay_q    <= '0;
            timer_q    <= '0;
            synced_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            local_ts_q <= local_ts_d;
            t_sent_q   <= t_sent_d;
            delay_q    <= delay_d;
            timer_q    <= timer_d;
            synced_q   <= synced_d;
        end
    end

    dtp_tx_arb u_tx_arb (
        .clock        (clock),
        .reset        (reset),
        .flush_i      (!link_up),
        .ack_req_i    (ack_req),
        .ack_ts_i     (rx_msg_ts),
        .init_req_i   (init_req),
        .beacon_req_i (beacon_req),
        .local_ts_i   (local_ts_q),
        .tx_ready_i   (tx_msg_ready),
        .tx_valid_o   (tx_msg_valid),
        .tx_msg_o     (tx_msg)
    );

    assign tx_msg_type = tx_msg.msg_type;
    assign tx_msg_ts   = tx_msg.ts;
    assign local_ts    = local_ts_q;
    assign delay       = delay_q;
    assign synced      = synced_q;

endmodule

// File: tb/tb_dtp_port_timestamp.sv
// Bench for dtp_port_timestamp: cycle-level protocol model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dtp_port_timestamp;
    import dtp_pkg::*;

    localparam int unsigned BP = 200;
    localparam int unsigned TO = 4096;
    localparam int P_DN = 0, P_SEND = 1, P_WAIT = 2, P_SYN = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            link_up = 1'b0;
    logic            rx_msg_valid = 1'b0;
    logic [1:0]      rx_msg_type = 2'd0;
    logic [TS_W-1:0] rx_msg_ts = '0;
    logic            tx_msg_ready = 1'b1;
    logic            tx_msg_valid;
    logic [1:0]      tx_msg_type;
    logic [TS_W-1:0] tx_msg_ts;
    logic [TS_W-1:0] local_ts;
    logic [15:0]     delay;
    logic            synced;

    always #5 clock = ~clock;

    dtp_port_timestamp #(
        .INCR          (1),
        .DELAY_W       (16),
        .BEACON_PERIOD (BP),
        .INIT_TIMEOUT  (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .link_up      (link_up),
        .rx_msg_valid (rx_msg_valid),
        .rx_msg_type  (rx_msg_type),
        .rx_msg_ts    (rx_msg_ts),
        .tx_msg_valid (tx_msg_valid),
        .tx_msg_ready (tx_msg_ready),
        .tx_msg_type  (tx_msg_type),
        .tx_msg_ts    (tx_msg_ts),
        .local_ts     (local_ts),
        .delay        (delay),
        .synced       (synced)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Protocol model: phase, the one-message tx slot and a wish list with priority ack > init > beacon.
    // Timers are expressed as cycles elapsed since the phase was entered.
    logic [TS_W-1:0] m_ts, m_tsent, m_slot_ts, m_echo;
    logic [15:0]     m_delay;
    logic [1:0]      m_k;
    bit              m_v, m_wa, m_wi, m_wb, m_synced;
    int              m_phase;
    longint          m_cyc, m_mark;

    task automatic model_reset();
        m_ts = '0; m_tsent = '0; m_slot_ts = '0; m_echo = '0; m_delay = '0; m_k = 2'd0;
        m_v = 0; m_wa = 0; m_wi = 0; m_wb = 0; m_synced = 0;
        m_phase = P_DN; m_cyc = 0; m_mark = 0;
    endtask

    task automatic model_step();
        logic [TS_W-1:0] n_ts, cand, half, n_slot_ts, n_echo;
        logic [1:0] n_k;
        bit is_init, is_ack, is_bcn, hs, n_v, n_wa, n_wi, n_wb;
        int ph;
        longint rel;
        is_init = rx_msg_valid && (rx_msg_type == 2'd0);
        is_ack  = rx_msg_valid && (rx_msg_type == 2'd1);
        is_bcn  = rx_msg_valid && (rx_msg_type == 2'd2);
        hs      = m_v && tx_msg_ready;
        rel     = m_cyc - m_mark;

        n_ts = m_ts + TS_W'(1);
        if (m_phase == P_SYN && is_bcn) begin
            cand = rx_msg_ts + TS_W'(m_delay);
            n_ts = ((cand > m_ts) ? cand : m_ts) + TS_W'(1);
        end

        n_v = m_v; n_k = m_k; n_slot_ts = m_slot_ts;
        n_wa = m_wa; n_wi = m_wi; n_wb = m_wb; n_echo = m_echo;
        if (hs) n_v = 0;
        if (!m_v) begin
            if (m_wa) begin n_v = 1; n_k = 2'd1; n_slot_ts = m_echo; n_wa = 0; end
            else if (m_wi) begin n_v = 1; n_k = 2'd0; n_slot_ts = m_ts; n_wi = 0; end
            else if (m_wb) begin n_v = 1; n_k = 2'd2; n_slot_ts = m_ts; n_wb = 0; end
        end

        ph = m_phase;
        case (m_phase)
            P_DN: if (link_up) begin ph = P_SEND; n_wi = 1; end
            P_SEND: if (hs && m_k == 2'd0) begin
                ph = P_WAIT; m_tsent = m_slot_ts; m_mark = m_cyc + 1;
            end
            P_WAIT: begin
                if (is_ack && rx_msg_ts == m_tsent) begin
                    half = (m_ts - m_tsent) >> 1;
                    m_delay = (half > TS_W'(65535)) ? 16'hffff : half[15:0];
                    ph = P_SYN; m_mark = m_cyc + 1;
                end else if (rel == longint'(TO - 1)) begin
                    ph = P_SEND; n_wi = 1;
                end
            end
            default: if ((rel % longint'(BP)) == longint'(BP - 1)) n_wb = 1;
        endcase
        if (is_init && m_phase != P_DN) begin n_wa = 1; n_echo = rx_msg_ts; end
        if (!link_up) begin ph = P_DN; n_v = 0; n_wa = 0; n_wi = 0; n_wb = 0; end

        m_ts = n_ts; m_v = n_v; m_k = n_k; m_slot_ts = n_slot_ts; m_echo = n_echo;
        m_wa = n_wa; m_wi = n_wi; m_wb = n_wb; m_phase = ph;
        m_synced = (ph == P_SYN);
        m_cyc++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("local_ts", 64'(local_ts), 64'(m_ts));
                chk("delay", 64'(delay), 64'(m_delay));
                chk("synced", 64'(synced), 64'(m_synced));
                chk("tx_valid", 64'(tx_msg_valid), 64'(m_v));
                if (m_v) begin
                    chk("tx_type", 64'(tx_msg_type), 64'(m_k));
                    chk("tx_ts", 64'(tx_msg_ts), 64'(m_slot_ts));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_rx(input logic [1:0] t, input logic [TS_W-1:0] ts);
        rx_msg_valid = 1'b1; rx_msg_type = t; rx_msg_ts = ts;
        tick(1);
        rx_msg_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!tx_msg_valid && n < budget) begin tick(1); n++; end
        n_total++;
        if (tx_msg_valid) n_pass++;
        else $display("FAIL %s: tx_msg_valid not seen within %0d cycles", name, budget);
    endtask

    task automatic wait_local(input logic [TS_W-1:0] target, input int budget, input string name);
        int n = 0;
        while (local_ts != target && n < budget) begin tick(1); n++; end
        n_total++;
        if (local_ts == target) n_pass++;
        else $display("FAIL %s: local_ts 0x%0h never reached 0x%0h", name, local_ts, target);
    endtask

    logic [TS_W-1:0] t_a, t_b, lv, big;
    logic [1:0]      kinds[$];
    logic [TS_W-1:0] tss[$];

    initial begin
        big = '1;
        // 1: reset, counting, mid-count reset, link down
        tick(2);
        reset = 1'b0;
        tick(5);
        chk("t1_count5", 64'(local_ts), 64'd5);
        #2 reset = 1'b1;
        #1;
        chk("t1_rst_ts", 64'(local_ts), 64'd0);
        chk("t1_rst_valid", 64'(tx_msg_valid), 64'd0);
        chk("t1_rst_sync", 64'(synced), 64'd0);
        chk("t1_rst_delay", 64'(delay), 64'd0);
        @(posedge clock); #1 reset = 1'b0;
        tick(1); chk("t1_ts1", 64'(local_ts), 64'd1);
        tick(1); chk("t1_ts2", 64'(local_ts), 64'd2);
        tick(1); chk("t1_ts3", 64'(local_ts), 64'd3);
        chk("t1_down_valid", 64'(tx_msg_valid), 64'd0);

        // 2: INIT exchange, ACK 40 clocks later -> delay 20
        link_up = 1'b1;
        wait_valid(20, "t2_init");
        chk("t2_init_type", 64'(tx_msg_type), 64'd0);
        t_a = tx_msg_ts;
        wait_local(t_a + TS_W'(40), 200, "t2_wait");
        send_rx(2'd1, t_a);
        chk("t2_synced", 64'(synced), 64'd1);
        chk("t2_delay", 64'(delay), 64'd20);

        // 3: beacon alignment, lower beacon, reserved type
        wait_local(TS_W'(1000), 2000, "t3_wait");
        send_rx(2'd2, TS_W'(5000));
        chk("t3_fwd", 64'(local_ts), 64'd5021);
        lv = local_ts;
        send_rx(2'd2, TS_W'(900));
        chk("t3_keep", 64'(local_ts), 64'(lv + TS_W'(1)));
        lv = local_ts;
        send_rx(2'd3, big);
        chk("t3_rsvd", 64'(local_ts), 64'(lv + TS_W'(1)));

        // 5: ready held low with a peer INIT; ACK goes first, then a single BEACON
        begin
            int n = 0;
            while (!(tx_msg_valid && tx_msg_type == 2'd2) && n < 300) begin tick(1); n++; end
            chk("t5_bcn_seen", 64'(tx_msg_valid && tx_msg_type == 2'd2), 64'd1);
        end
        tick(1);
        tx_msg_ready = 1'b0;
        tick(5);
        send_rx(2'd0, TS_W'(53'h1234));
        tick(2);
        chk("t5_ack_valid", 64'(tx_msg_valid), 64'd1);
        chk("t5_ack_type", 64'(tx_msg_type), 64'd1);
        tick(492);
        chk("t5_hold_valid", 64'(tx_msg_valid), 64'd1);
        chk("t5_hold_type", 64'(tx_msg_type), 64'd1);
        chk("t5_hold_ts", 64'(tx_msg_ts), 64'h1234);
        tx_msg_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (tx_msg_valid) begin kinds.push_back(tx_msg_type); tss.push_back(tx_msg_ts); end
            tick(1);
        end
        chk("t5_msg_count", 64'(kinds.size()), 64'd2);
        if (kinds.size() >= 2) begin
            chk("t5_first_ack", 64'(kinds[0]), 64'd1);
            chk("t5_first_ts", 64'(tss[0]), 64'h1234);
            chk("t5_then_bcn", 64'(kinds[1]), 64'd2);
        end

        // 6: wrap near 2^53-1, then link drop with a pending message
        send_rx(2'd2, big - TS_W'(25));
        chk("t6_near_max", 64'(local_ts), 64'(big - TS_W'(4)));
        tick(5);
        chk("t6_wrap", 64'(local_ts), 64'd1 - 64'd1);
        tx_msg_ready = 1'b0;
        wait_valid(250, "t6_pending");
        link_up = 1'b0;
        lv = local_ts;
        tick(1);
        chk("t6_drop_valid", 64'(tx_msg_valid), 64'd0);
        chk("t6_drop_sync", 64'(synced), 64'd0);
        chk("t6_drop_delay", 64'(delay), 64'd20);
        chk("t6_drop_count", 64'(local_ts), 64'(lv + TS_W'(1)));
        tx_msg_ready = 1'b1;

        // 4: no ACK -> INIT retried; beacon and wrong ACK ignored in INIT_WAIT
        tick(3);
        link_up = 1'b1;
        wait_valid(20, "t4_init1");
        t_a = tx_msg_ts;
        tick(1);
        wait_valid(4200, "t4_init2");
        t_b = tx_msg_ts;
        chk("t4_retry_type", 64'(tx_msg_type), 64'd0);
        chk("t4_retry_gap", 64'(t_b - t_a), 64'd4098);
        tick(1);
        lv = local_ts;
        send_rx(2'd2, big - TS_W'(100));
        chk("t4_bcn_ignored", 64'(local_ts), 64'(lv + TS_W'(1)));
        send_rx(2'd1, t_b + TS_W'(1));
        tick(3);
        chk("t4_bad_ack", 64'(synced), 64'd0);
        wait_local(t_b + TS_W'(64), 200, "t4_wait");
        send_rx(2'd1, t_b);
        chk("t4_synced", 64'(synced), 64'd1);
        chk("t4_delay", 64'(delay), 64'd32);
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
